// File: rtl/torwave_frame_sched.sv
// Frame playback scheduler: on a 10 ms strobe, waits cfg_offset clocks,
// then streams cfg_len words from waveform memory out over AXI-Stream.
// Ports: s_axis_aclk/s_axis_areset (async, active-high), enable,
//   start_10ms, overrun_clr, cfg_base/cfg_len/cfg_offset;
//   mem_rd_en/mem_rd_addr/mem_rd_data (1-cycle read latency);
//   m0_data_* AXI-Stream master; busy, overrun, frame_cnt status.
// Macro TORWAVE_FRAME_SCHED_OVERRUN_EN enables sticky overrun reporting.
module torwave_frame_sched #(
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 11,
  parameter int OFFSET_W = 24
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_areset,
  input  logic                enable,
  input  logic                start_10ms,
  input  logic                overrun_clr,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [OFFSET_W-1:0] cfg_offset,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [63:0]         mem_rd_data,
  output logic [63:0]         m0_data_tdata,
  output logic [7:0]          m0_data_tkeep,
  output logic                m0_data_tvalid,
  output logic                m0_data_tlast,
  output logic                m0_data_tuser,
  input  logic                m0_data_tready,
  output logic                busy,
  output logic                overrun,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_PLAY, S_DRAIN
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issued;
  logic [LEN_W-1:0]    sent;
  logic [OFFSET_W-1:0] wait_cnt;
  logic [ADDR_W-1:0]   rd_addr;
  logic                inflight;
  logic [63:0]         buf_q [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          occ;
  logic                pop;
  logic                rd_go;
  logic [2:0]          occ_after;

  assign m0_data_tvalid = (occ != 2'd0);
  assign m0_data_tdata  = buf_q[rd_ptr];
  assign m0_data_tkeep  = 8'hFF;
  assign m0_data_tuser  = m0_data_tvalid && (sent == '0);
  assign m0_data_tlast  = m0_data_tvalid &&
                          (sent == len_q - LEN_W'(1));
  assign pop            = m0_data_tvalid && m0_data_tready;
  assign busy           = (state != S_IDLE);
  assign mem_rd_addr    = rd_addr;

  // Credit counts the slot freed by this cycle's pop, so a
  // continuously-ready sink sees back-to-back beats.
  assign occ_after = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight};
  assign rd_go     = (state == S_PLAY) && (occ_after < 3'd2);
  assign mem_rd_en = rd_go;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      sent      <= '0;
      wait_cnt  <= '0;
      rd_addr   <= '0;
      inflight  <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= '0;
      frame_cnt <= '0;
    end else begin
      inflight <= rd_go;
      if (inflight) begin
        buf_q[wr_ptr] <= mem_rd_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        sent   <= sent + LEN_W'(1);
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (rd_go) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        issued  <= issued + LEN_W'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (start_10ms && enable) begin
            len_q     <= cfg_len;
            rd_addr   <= cfg_base;
            issued    <= '0;
            sent      <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            wait_cnt  <= (cfg_offset == '0) ? '0 :
                         cfg_offset - OFFSET_W'(1);
            if (cfg_offset == '0 && cfg_len != '0)
              state <= S_PLAY;
            else
              state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0)
            state <= (len_q == '0) ? S_IDLE : S_PLAY;
          else
            wait_cnt <= wait_cnt - OFFSET_W'(1);
        end
        S_PLAY: begin
          if (rd_go && issued == len_q - LEN_W'(1))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && m0_data_tlast)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TORWAVE_FRAME_SCHED_OVERRUN_EN
  // A stray strobe wins over a same-cycle clear.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset)
      overrun <= 1'b0;
    else if (start_10ms && state != S_IDLE)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = overrun_clr;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_torwave_frame_sched.sv
// Directed self-checking bench for torwave_frame_sched.
// Uses an in-bench waveform memory with 1-cycle read latency.
module tb_torwave_frame_sched;

`ifdef TORWAVE_FRAME_SCHED_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, start, clr;
  logic [9:0]  cfg_base;
  logic [10:0] cfg_len;
  logic [23:0] cfg_off;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tlast, tuser, tready;
  logic        busy, overrun;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_fc = 16'd0;

  always #5 clk = ~clk;

  torwave_frame_sched dut (
    .s_axis_aclk    (clk),
    .s_axis_areset  (rst),
    .enable         (enable),
    .start_10ms     (start),
    .overrun_clr    (clr),
    .cfg_base       (cfg_base),
    .cfg_len        (cfg_len),
    .cfg_offset     (cfg_off),
    .mem_rd_en      (rd_en),
    .mem_rd_addr    (rd_addr),
    .mem_rd_data    (rd_data),
    .m0_data_tdata  (tdata),
    .m0_data_tkeep  (tkeep),
    .m0_data_tvalid (tvalid),
    .m0_data_tlast  (tlast),
    .m0_data_tuser  (tuser),
    .m0_data_tready (tready),
    .busy           (busy),
    .overrun        (overrun),
    .frame_cnt      (frame_cnt)
  );

  function automatic logic [63:0] dat(input logic [9:0] a);
    return {16'hC0DE, 6'h0, a, 22'h2AAAAA, a};
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= dat(rd_addr);
    else       rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_en"}, {63'd0, rd_en}, 64'd0);
    chk({tag, " addr"}, {54'd0, rd_addr}, 64'd0);
    chk({tag, " tvalid"}, {63'd0, tvalid}, 64'd0);
    chk({tag, " tlast"}, {63'd0, tlast}, 64'd0);
    chk({tag, " tuser"}, {63'd0, tuser}, 64'd0);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " overrun"}, {63'd0, overrun}, 64'd0);
    chk({tag, " frame_cnt"}, {48'd0, frame_cnt}, 64'd0);
    chk({tag, " tdata"}, tdata, 64'd0);
  endtask

  // Run one frame; optional stray strobe/clear at cycle 'stray',
  // optional reset right after beat 'rst_beats'.
  task automatic play(input logic [9:0] base, input logic [10:0] len,
                      input logic [23:0] off, input bit tog,
                      input int stray, input bit stray_clr,
                      input int rst_beats);
    int reads, acc, first_rd, first_v, last_acc, busy_cnt, budget;
    bit prev_stall, aborted;
    logic [63:0] prev_d;
    reads = 0; acc = 0; first_rd = -1; first_v = -1;
    last_acc = -1; busy_cnt = 0; prev_stall = 0; aborted = 0;
    prev_d = '0;
    budget = int'(off) + 4 * int'(len) + 20;
    cfg_base = base; cfg_len = len; cfg_off = off;
    enable = 1'b1; start = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    enable = 1'b0;
    exp_fc = exp_fc + 16'd1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tready = tog ? (cyc % 2 == 1) : 1'b1;
      start  = (cyc == stray);
      clr    = (cyc == stray) && stray_clr;
      #1;
      if (busy) busy_cnt++;
      if (busy) chk("outstanding<=2", {63'd0, (reads - acc) <= 2}, 64'd1);
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_addr", {54'd0, rd_addr}, {54'd0, base + 10'(reads)});
        reads++;
      end
      if (tvalid) begin
        if (first_v < 0) first_v = cyc;
        if (prev_stall) chk("stall stable", tdata, prev_d);
        chk("tkeep", {56'd0, tkeep}, 64'hFF);
      end
      if (tvalid && tready) begin
        chk("tdata", tdata, dat(base + 10'(acc)));
        chk("tuser", {63'd0, tuser}, {63'd0, acc == 0});
        chk("tlast", {63'd0, tlast}, {63'd0, acc == int'(len) - 1});
        acc++;
        if (acc == int'(len)) last_acc = cyc;
        if (acc == rst_beats) begin
          start = 1'b0; clr = 1'b0;
          rst = 1'b1;
          #1;
          chk_zero("reset-abort");
          @(posedge clk); #1;
          rst = 1'b0;
          exp_fc = 16'd0;
          repeat (4) @(posedge clk);
          #1;
          chk("no beats after reset", {63'd0, tvalid}, 64'd0);
          aborted = 1;
          break;
        end
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      if (last_acc > 0 && cyc == last_acc + 1) begin
        chk("idle after tlast", {63'd0, busy}, 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; clr = 1'b0; tready = 1'b1;
    if (!aborted) begin
      chk("reads", 64'(reads), 64'(len));
      chk("beats", 64'(acc), 64'(len));
      chk("frame_cnt", {48'd0, frame_cnt}, {48'd0, exp_fc});
      if (len != 0) begin
        chk("first rd cycle", 64'(first_rd), 64'(1 + int'(off)));
        chk("first tvalid cycle", 64'(first_v), 64'(3 + int'(off)));
        if (!tog)
          chk("tlast cycle", 64'(last_acc),
              64'(2 + int'(off) + int'(len)));
      end else begin
        chk("len0 no tvalid", 64'(first_v), 64'(-1));
        chk("len0 busy cycles",
            {63'd0, busy_cnt >= int'(off) && busy_cnt <= int'(off) + 1},
            64'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start = 1'b0; clr = 1'b0;
    cfg_base = '0; cfg_len = '0; cfg_off = '0; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // strobe with enable low is ignored
    cfg_len = 11'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("disabled busy", {63'd0, busy}, 64'd0);
    chk("disabled frame_cnt", {48'd0, frame_cnt}, 64'd0);

    // address wrap, back-to-back beats
    play(10'h3FE, 11'd4, 24'd0, 1'b0, -1, 1'b0, -1);
    // long offset, stalling sink
    play(10'h120, 11'd8, 24'd100, 1'b1, -1, 1'b0, -1);
    // stray strobe during PLAY
    play(10'h010, 11'd4, 24'd2, 1'b0, 5, 1'b0, -1);
    chk("overrun after stray", {63'd0, overrun}, {63'd0, OVR});
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("overrun cleared", {63'd0, overrun}, 64'd0);
    // stray strobe + clear on final beat acceptance
    play(10'h020, 11'd3, 24'd1, 1'b0, 6, 1'b1, -1);
    chk("overrun set wins", {63'd0, overrun}, {63'd0, OVR});
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("overrun cleared 2", {63'd0, overrun}, 64'd0);
    // single-word frame
    play(10'h3FF, 11'd1, 24'd3, 1'b0, -1, 1'b0, -1);
    // empty frame
    play(10'h055, 11'd0, 24'd5, 1'b0, -1, 1'b0, -1);
    // reset after beat 3 of 8, then fresh frame
    play(10'h100, 11'd8, 24'd0, 1'b0, -1, 1'b0, 3);
    play(10'h200, 11'd2, 24'd0, 1'b0, -1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
